// File: rtl/mips_isa_pkg.sv
// Shared MIPS encoding constants: mnemonic codes, opcodes, funct values,
// REGIMM rt selectors, FSM state encoding and word-packing helpers.
package mips_isa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam int FIFO_W = 42;  // 32-bit word plus 10 spare bits

  // Mnemonic codes (decoder numbering)
  localparam logic [5:0] M_ADD   = 6'd0,  M_ADDU  = 6'd1,  M_AND   = 6'd2,
                         M_NOR   = 6'd3,  M_OR    = 6'd4,  M_SLT   = 6'd5,
                         M_SLTU  = 6'd6,  M_SUB   = 6'd7,  M_SUBU  = 6'd8,
                         M_XOR   = 6'd9,  M_SLLV  = 6'd10, M_SRAV  = 6'd11,
                         M_SRLV  = 6'd12, M_SLL   = 6'd13, M_SRA   = 6'd14,
                         M_SRL   = 6'd15, M_JR    = 6'd16, M_BEQ   = 6'd17,
                         M_BNE   = 6'd18, M_BGEZ  = 6'd19, M_BGTZ  = 6'd20,
                         M_BLEZ  = 6'd21, M_BLTZ  = 6'd22, M_J     = 6'd23,
                         M_ADDI  = 6'd24, M_ADDIU = 6'd25, M_ANDI  = 6'd26,
                         M_XORI  = 6'd27, M_ORI   = 6'd28, M_SLTI  = 6'd29,
                         M_SLTIU = 6'd30, M_LW    = 6'd31, M_SW    = 6'd32;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_REGIMM = 6'b000001,
                         OP_J       = 6'b000010, OP_BEQ    = 6'b000100,
                         OP_BNE     = 6'b000101, OP_BLEZ   = 6'b000110,
                         OP_BGTZ    = 6'b000111, OP_ADDI   = 6'b001000,
                         OP_ADDIU   = 6'b001001, OP_SLTI   = 6'b001010,
                         OP_SLTIU   = 6'b001011, OP_ANDI   = 6'b001100,
                         OP_ORI     = 6'b001101, OP_XORI   = 6'b001110,
                         OP_LW      = 6'b100011, OP_SW     = 6'b101011;

  // R-type funct field
  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010,
                         F_SRA  = 6'b000011, F_SLLV = 6'b000100,
                         F_SRLV = 6'b000110, F_SRAV = 6'b000111,
                         F_JR   = 6'b001000, F_ADD  = 6'b100000,
                         F_ADDU = 6'b100001, F_SUB  = 6'b100010,
                         F_SUBU = 6'b100011, F_AND  = 6'b100100,
                         F_OR   = 6'b100101, F_XOR  = 6'b100110,
                         F_NOR  = 6'b100111, F_SLT  = 6'b101010,
                         F_SLTU = 6'b101011;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001;

  function automatic logic [31:0] r_word(input logic [4:0] rs, rt, rd, sh,
                                         input logic [5:0] funct);
    return {OP_SPECIAL, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op,
                                         input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO with registered storage; head is read combinationally.
module enc_fifo2 #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              rd_ptr, wr_ptr;
  logic              do_push, do_pop;

  // Guard against overflow/underflow regardless of caller behaviour
  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop  && (count != 2'd0);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset discards all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Field-bundle to MIPS word encoder feeding an instruction-memory write port
// through a 2-deep FIFO, with IDLE/RUN/HALT control and address sequencing.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_addr,
  output logic [31:0] out_word,
  output logic        err,
  output logic        wrapped,
  output logic [1:0]  state_o
);

  state_e             state, state_nxt;
  logic [9:0]         addr_q, addr_nxt;
  logic               err_q, err_nxt, wrap_q, wrap_nxt;
  logic [31:0]        enc_word;
  logic               legal, accept, push, pop;
  logic [1:0]         count;
  logic [FIFO_W-1:0]  fifo_din, fifo_dout;
  logic               unused_spare;

  // Combinational encode of the presented field bundle
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (mnem)
      M_ADD:   enc_word = r_word(rs, rt, rd, 5'd0, F_ADD);
      M_ADDU:  enc_word = r_word(rs, rt, rd, 5'd0, F_ADDU);
      M_AND:   enc_word = r_word(rs, rt, rd, 5'd0, F_AND);
      M_NOR:   enc_word = r_word(rs, rt, rd, 5'd0, F_NOR);
      M_OR:    enc_word = r_word(rs, rt, rd, 5'd0, F_OR);
      M_SLT:   enc_word = r_word(rs, rt, rd, 5'd0, F_SLT);
      M_SLTU:  enc_word = r_word(rs, rt, rd, 5'd0, F_SLTU);
      M_SUB:   enc_word = r_word(rs, rt, rd, 5'd0, F_SUB);
      M_SUBU:  enc_word = r_word(rs, rt, rd, 5'd0, F_SUBU);
      M_XOR:   enc_word = r_word(rs, rt, rd, 5'd0, F_XOR);
      M_SLLV:  enc_word = r_word(rs, rt, rd, 5'd0, F_SLLV);
      M_SRAV:  enc_word = r_word(rs, rt, rd, 5'd0, F_SRAV);
      M_SRLV:  enc_word = r_word(rs, rt, rd, 5'd0, F_SRLV);
      M_SLL:   enc_word = r_word(5'd0, rt, rd, shamt, F_SLL);
      M_SRA:   enc_word = r_word(5'd0, rt, rd, shamt, F_SRA);
      M_SRL:   enc_word = r_word(5'd0, rt, rd, shamt, F_SRL);
      M_JR:    enc_word = r_word(rs, 5'd0, 5'd0, 5'd0, F_JR);
      M_BEQ:   enc_word = i_word(OP_BEQ, rs, rt, imm);
      M_BNE:   enc_word = i_word(OP_BNE, rs, rt, imm);
      M_BGEZ:  enc_word = i_word(OP_REGIMM, rs, RT_BGEZ, imm);
      M_BGTZ:  enc_word = i_word(OP_BGTZ, rs, 5'd0, imm);
      M_BLEZ:  enc_word = i_word(OP_BLEZ, rs, 5'd0, imm);
      M_BLTZ:  enc_word = i_word(OP_REGIMM, rs, RT_BLTZ, imm);
      M_J:     enc_word = {OP_J, target};
      M_ADDI:  enc_word = i_word(OP_ADDI, rs, rt, imm);
      M_ADDIU: enc_word = i_word(OP_ADDIU, rs, rt, imm);
      M_ANDI:  enc_word = i_word(OP_ANDI, rs, rt, imm);
      M_XORI:  enc_word = i_word(OP_XORI, rs, rt, imm);
      M_ORI:   enc_word = i_word(OP_ORI, rs, rt, imm);
      M_SLTI:  enc_word = i_word(OP_SLTI, rs, rt, imm);
      M_SLTIU: enc_word = i_word(OP_SLTIU, rs, rt, imm);
      M_LW:    enc_word = i_word(OP_LW, rs, rt, imm);
      M_SW:    enc_word = i_word(OP_SW, rs, rt, imm);
      default: legal    = 1'b0;
    endcase
  end

  // Full FIFO blocks input even if a pop happens the same cycle
  assign in_ready  = (state == S_RUN) && (count != 2'd2);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Spare bits carry the mnemonic for debug visibility only
  assign fifo_din     = {4'd0, mnem, enc_word};
  assign unused_spare = ^fifo_dout[FIFO_W-1:32];

  enc_fifo2 #(.W(FIFO_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (count)
  );

  assign out_word = out_valid ? fifo_dout[31:0] : 32'd0;
  assign out_addr = addr_q;
  assign err      = err_q;
  assign wrapped  = wrap_q;
  assign state_o  = state;

  // Next-state, address sequencing and sticky flags
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    err_nxt   = err_q;
    wrap_nxt  = wrap_q;
    if (pop) begin
      addr_nxt = addr_q + 10'd1;
      if (addr_q == 10'h3FF) wrap_nxt = 1'b1;
    end
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_RUN;
        addr_nxt  = base_addr;
        wrap_nxt  = 1'b0;
      end
      S_RUN: if (accept && !legal) begin
        state_nxt = S_HALT;
        err_nxt   = 1'b1;
      end
      S_HALT: if (start && !out_valid) begin
        state_nxt = S_RUN;
        err_nxt   = 1'b0;
        addr_nxt  = base_addr;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= 10'd0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      err_q  <= err_nxt;
      wrap_q <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected {addr,word} queued on input
// acceptance, compared when the write handshake is observed.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  mnem = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_addr;
  logic [31:0] out_word;
  logic        err, wrapped;
  logic [1:0]  state_o;

  int          errs = 0;
  int          checks = 0;
  logic [41:0] sb[$];
  logic [9:0]  push_addr = '0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_word(out_word), .err(err), .wrapped(wrapped), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Write-port monitor: compare every handshake against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        logic [41:0] e;
        e = sb.pop_front();
        chk("out_word", 64'(out_word), 64'(e[31:0]));
        chk("out_addr", 64'(out_addr), 64'(e[41:32]));
      end
    end
  end

  task automatic send(input logic [5:0] m, input logic [4:0] a, b, c, d,
                      input logic [15:0] im, input logic [25:0] tg,
                      input logic [31:0] exp_w, input bit exp_push);
    int n;
    @(negedge clk);
    mnem = m; rs = a; rt = b; rd = c; shamt = d; imm = im; target = tg;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (exp_push) begin
      sb.push_back({push_addr, exp_w});
      push_addr = push_addr + 10'd1;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [9:0] b);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin @(negedge clk); n++; end
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_sb", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    rst_n = 1'b1;

    // IDLE -> RUN with base 0x010
    pulse_start(10'h010); push_addr = 10'h010;
    chk("run_state", 64'(state_o), 64'd1);
    chk("run_addr", 64'(out_addr), 64'h010);
    chk("run_in_ready", 64'(in_ready), 64'd1);

    // ADD with one-cycle latency to out_valid
    out_ready = 1'b1;
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 32'h00221820, 1'b1);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_word", 64'(out_word), 64'h00221820);
    chk("lat_addr", 64'(out_addr), 64'h010);

    // Assorted formats
    send(6'd13, 5'd5, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 32'h000220C0, 1'b1);   // SLL
    send(6'd19, 5'd4, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'h0, 32'h0481FFFE, 1'b1); // BGEZ
    send(6'd17, 5'd3, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h10650010, 1'b1); // BEQ
    send(6'd23, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0123456, 32'h08123456, 1'b1); // J
    send(6'd31, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA80004, 1'b1); // LW
    send(6'd16, 5'd31, 5'd7, 5'd9, 5'd3, 16'h0, 26'h0, 32'h03E00008, 1'b1);   // JR
    send(6'd11, 5'd2, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0, 32'h00432007, 1'b1);    // SRAV
    send(6'd22, 5'd6, 5'd9, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h04C08000, 1'b1); // BLTZ
    send(6'd15, 5'd9, 5'd1, 5'd2, 5'd31, 16'h0, 26'h0, 32'h000117C2, 1'b1);   // SRL
    wait_drain();

    // Backpressure: two queued, third blocked, head held stable
    out_ready = 1'b0;
    send(6'd28, 5'd1, 5'd2, 5'd0, 5'd0, 16'hABCD, 26'h0, 32'h3422ABCD, 1'b1); // ORI
    send(6'd32, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 26'h0, 32'hAC850008, 1'b1); // SW
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    fork
      send(6'd20, 5'd7, 5'd3, 5'd0, 5'd0, 16'h0001, 26'h0, 32'h1CE00001, 1'b1); // BGTZ
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_word", 64'(out_word), 64'h3422ABCD);
          chk("bp_hold_addr", 64'(out_addr), 64'h01A);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // start while RUN is ignored; addresses continue
    pulse_start(10'h200);
    chk("run_start_ign", 64'(state_o), 64'd1);
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820, 1'b1);
    wait_drain();

    // Illegal mnemonic with one word still queued
    out_ready = 1'b0;
    send(6'd28, 5'd1, 5'd2, 5'd0, 5'd0, 16'hABCD, 26'h0, 32'h3422ABCD, 1'b1);
    send(6'd40, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_state", 64'(state_o), 64'd2);
    chk("ill_in_ready", 64'(in_ready), 64'd0);
    chk("ill_drain_valid", 64'(out_valid), 64'd1);
    pulse_start(10'h3FF);
    chk("halt_start_ign", 64'(state_o), 64'd2);
    chk("halt_err_kept", 64'(err), 64'd1);
    out_ready = 1'b1;
    wait_drain();

    // Restart from HALT at 1023; two words wrap to address 0
    pulse_start(10'h3FF); push_addr = 10'h3FF;
    chk("restart_state", 64'(state_o), 64'd1);
    chk("restart_err", 64'(err), 64'd0);
    chk("restart_addr", 64'(out_addr), 64'h3FF);
    send(6'd20, 5'd7, 5'd3, 5'd0, 5'd0, 16'h0001, 26'h0, 32'h1CE00001, 1'b1);
    send(6'd15, 5'd9, 5'd1, 5'd2, 5'd31, 16'h0, 26'h0, 32'h000117C2, 1'b1);
    wait_drain();
    chk("wrap_flag", 64'(wrapped), 64'd1);
    chk("wrap_addr", 64'(out_addr), 64'h001);

    // Reset with two words queued
    out_ready = 1'b0;
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820, 1'b1);
    send(6'd32, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 26'h0, 32'hAC850008, 1'b1);
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_word", 64'(out_word), 64'd0);
    chk("mid_rst_state", 64'(state_o), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_addr", 64'(out_addr), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_low_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_state", 64'(state_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  single-cycle pulse that loads base_addr and enters RUN.
REQ-004 base_addr  input  10  word address of the first instruction written after start.
REQ-005 in_valid / in_ready  input / output  1 / 1  field-bundle handshake; a transfer occurs when both are high on a clk edge.
REQ-006 mnem  input  6  mnemonic code: 0-32 legal, 33-63 illegal.
REQ-007 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-008 imm  input  16  immediate or branch offset field.
REQ-009 target  input  26  jump target field.
REQ-010 out_valid / out_ready  output / input  1 / 1  instruction-memory write handshake.
REQ-011 out_addr  output  10  word address of the head word.
REQ-012 out_word  output  32  encoded instruction at the FIFO head.
REQ-013 err  output  1  sticky flag: an illegal mnemonic was accepted.
REQ-014 wrapped  output  1  sticky flag: out_addr wrapped from 1023 to 0.
REQ-015 state_o  output  2  current state: IDLE=0, RUN=1, HALT=2.

Function
REQ-016 Mnemonic order 0-32: ADD ADDU AND NOR OR SLT SLTU SUB SUBU XOR SLLV SRAV SRLV SLL SRA SRL JR BEQ BNE BGEZ BGTZ BLEZ BLTZ J ADDI ADDIU ANDI XORI ORI SLTI SLTIU LW SW.
REQ-017 R-type words: op=000000, then rs, rt, rd, shamt, funct. Funct values: ADD 100000, ADDU 100001, AND 100100, NOR 100111, OR 100101, SLT 101010, SLTU 101011, SUB 100010, SUBU 100011, XOR 100110, SLLV 000100, SRAV 000111, SRLV 000110, SLL 000000, SRA 000011, SRL 000010, JR 001000.
REQ-018 Field forcing: SLL/SRA/SRL force rs=0; SLLV/SRAV/SRLV and all other R-type except shifts force shamt=0; JR forces rt=rd=shamt=0.
REQ-019 Branch words are {op, rs, rtfield, imm}. Opcode and rt field: BEQ 000100 with rt; BNE 000101 with rt; BGEZ 000001 with rt=00001; BLTZ 000001 with rt=00000; BGTZ 000111 with rt=00000; BLEZ 000110 with rt=00000.
REQ-020 J word is {000010, target}.
REQ-021 I-type words are {op, rs, rt, imm}. Opcodes: ADDI 001000, ADDIU 001001, ANDI 001100, XORI 001110, ORI 001101, SLTI 001010, SLTIU 001011, LW 100011, SW 101011.
REQ-022 Encoding is combinational from the input fields; the encoded word is pushed into a 2-entry FIFO on the in handshake edge, so out_valid rises 1 cycle after acceptance into an empty FIFO.
REQ-023 in_ready = (state==RUN) && (FIFO count<2); a simultaneous pop never enables a push into a full FIFO.
REQ-024 out_valid = FIFO non-empty; out_word and out_addr shall hold stable while out_valid && !out_ready.
REQ-025 out_addr increments by 1 on each out handshake; 1023+1 -> 0 and sets wrapped.
REQ-026 IDLE --start--> RUN: out_addr=base_addr, wrapped cleared.
REQ-027 RUN --accepted mnem>32--> HALT: word not pushed, err=1; queued words continue draining.
REQ-028 In RUN, start is ignored.
REQ-029 HALT --start && FIFO empty--> RUN: err cleared, out_addr reloaded; start in HALT with FIFO non-empty is ignored.
REQ-030 Push and pop in the same cycle keep count unchanged and preserve FIFO order.

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, FIFO empty, out_valid=0, out_addr=0, out_word=0, err=0, wrapped=0, in_ready=0.
REQ-032 Reset mid-transfer discards all queued words; no write handshake completes while rst_n is low.

Structure
REQ-033 Mnemonic codes, opcode/funct/rt constants and state encodings live in shared package mips_isa_pkg, consistent with the decoder constants.
REQ-034 One sub-module, enc_fifo2 (2-entry FIFO, 42-bit entry: word plus spare), is instantiated; the encoding logic stays inline.

Verification
REQ-035 After start with base 0x010: push ADD rs=1 rt=2 rd=3 shamt=7 -> out_word 0x00221820 at out_addr 0x010, one cycle after acceptance.
REQ-036 Push SLL rs=5 rt=2 rd=4 shamt=3, then BGEZ rs=4 imm=0xFFFE -> 0x000220C0, then 0x0481FFFE.
REQ-037 Hold out_ready=0 and push 3 words -> in_ready=0 after the 2nd; raise out_ready -> words emerge in order at consecutive addresses.
REQ-038 With base 1023, write 2 words -> addresses 1023 then 0, and wrapped=1.
REQ-039 Push mnem=40 -> err=1, state HALT, in_ready=0; start with FIFO empty -> RUN, err=0.
REQ-040 Assert rst_n low with 2 words queued -> out_valid=0 and FIFO empty immediately; state IDLE.
